and_or_pla: RTL and testbench
=============================

Name: and_or_pla

Overview:
- Parametrised, runtime-programmable sum-of-products logic array. It generalises a fixed AND-OR gate network to N_IN inputs, N_TERMS product terms and N_OUT outputs, with per-output polarity.
- The array function is loaded serially through a ready/valid config port and committed atomically, so evaluation never uses a half-loaded function.
- Evaluation is a 2-stage registered pipeline with a valid flag.
- Sits between switch/GPIO synchronisers and LED/output logic in the tutorial designs.

Parameters:
- N_IN, 4, number of logic inputs (>=1)
- N_TERMS, 4, number of product terms (>=1)
- N_OUT, 2, number of outputs (>=1)
- CFG_W, N_TERMS*2*N_IN + N_OUT*N_TERMS + N_OUT, config vector width (derived localparam, not overridable)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  sample on `in` is valid this cycle
- in  input  N_IN  logic inputs
- out_valid  output  1  `out` holds a result
- out  output  N_OUT  registered array outputs
- cfg_start  input  1  single-cycle pulse that begins or restarts a config load
- cfg_valid  input  1  cfg_bit is valid
- cfg_bit  input  1  serial config bit, MSB of the config vector first
- cfg_ready  output  1  high while the block is in LOAD
- cfg_done  output  1  one-cycle pulse, the cycle after commit

Behaviour:
- Reset (async assert, sync release): out=0, out_valid=0, cfg_ready=0, cfg_done=0, active config C=0 (all outputs evaluate 0), shadow=0, bit counter=0, FSM=IDLE.
- Config vector layout C[CFG_W-1:0]:
  - Term t true mask: C[2*N_IN*t + N_IN-1 : 2*N_IN*t].
  - Term t complement mask: C[2*N_IN*t + 2*N_IN-1 : 2*N_IN*t + N_IN].
  - With B = 2*N_IN*N_TERMS, output o OR-mask: C[B + N_TERMS*o + N_TERMS-1 : B + N_TERMS*o].
  - With P = B + N_OUT*N_TERMS, output o polarity: C[P+o].
- Term semantics: term t = AND over i of (in[i] if true[i]) and (~in[i] if comp[i]).
  - No mask bits set -> term = 1.
  - true[i] and comp[i] both set -> term = 0.
- Output semantics: out[o] = (OR of terms selected by the OR-mask) XOR polarity[o]. An empty OR-mask gives 0, or 1 when inverted.
- Pipeline:
  - Stage 1 registers the term vector, a copy of the OR-masks, the polarity bits and in_valid.
  - Stage 2 registers out and out_valid.
  - Latency is 2 cycles, throughput 1 per cycle, no backpressure.
  - out holds its value when out_valid=0.
- FSM states IDLE and LOAD:
  - IDLE -> LOAD on cfg_start: counter=0, shadow=0.
  - In LOAD, cfg_ready=1. Each cycle with cfg_valid & cfg_ready: shadow <= {shadow[CFG_W-2:0], cfg_bit}, counter++.
  - On the handshake of bit CFG_W: active C <= {shadow[CFG_W-2:0], cfg_bit}, FSM -> IDLE, cfg_done=1 on the next cycle.
  - cfg_start during LOAD restarts the load: counter=0, shadow=0, and any cfg_valid in that same cycle is ignored.
  - cfg_valid outside LOAD is ignored.
- Commit coherence: a sample accepted in the commit cycle uses the old config. Samples accepted from the next cycle use the new config. Stage 2 always uses the OR-mask and polarity captured with its own stage-1 sample, never mixed.
- Evaluation continues, unaffected, throughout LOAD.
- rst_n asserted mid-load: the load is discarded, C returns to 0, and the pipeline valid bits clear immediately.

Decomposition:
- Shared package and_or_pla_pkg:
  - state enum {IDLE, LOAD}
  - functions cfg_width(n_in, n_terms, n_out), term_true_lsb(t, n_in), or_mask_lsb(o, n_in, n_terms, n_out)
- One sub-module: and_or_pla_term (combinational single product term, N_IN generic), instantiated N_TERMS times in a generate loop.
- The FSM, counter, shadow register and pipeline stay in the top module.

Test Plan:
- Override N_IN=3, N_TERMS=2, N_OUT=1 (CFG_W=15).
  - After reset, drive in=3'b111 with in_valid -> out=0, out_valid high exactly 2 cycles later.
  - Load C=15'h3103 (term0=in0&in1, term1=in2, OR=11, polarity 0) -> cfg_done after 15 handshakes. Sweep all 8 inputs -> out=(in0&in1)|in2, e.g. 3'b011->1, 3'b001->0, 3'b100->1.
  - Load C=15'h7103 -> inverted function, 3'b001->1, 3'b111->0.
  - Stream inputs every cycle across the commit cycle -> samples before and in the commit cycle use the old config, later ones the new. No glitch mixing masks.
  - Pulse cfg_start after 7 bits, then send the full 15 bits of 0x3103 with cfg_valid gaps -> correct function, cfg_done only once.
  - Assert rst_n mid-load (bit 9) and mid-stream -> out=0, out_valid=0 immediately, cfg_ready=0. Resume -> out=0 for all inputs.

Source files
------------

// File: rtl/and_or_pla_pkg.sv
// Shared definitions for the programmable AND-OR array.
//   - state_e       : config loader states
//   - cfg_width     : total config vector width for a given geometry
//   - term_true_lsb : LSB of term t's true mask (complement mask follows at +n_in)
//   - or_mask_lsb   : LSB of output o's OR-mask; o == n_out gives the polarity field LSB
package and_or_pla_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    function automatic int unsigned cfg_width(input int unsigned n_in,
                                              input int unsigned n_terms,
                                              input int unsigned n_out);
        return n_terms * 2 * n_in + n_out * n_terms + n_out;
    endfunction

    function automatic int unsigned term_true_lsb(input int unsigned t,
                                                  input int unsigned n_in);
        return 2 * n_in * t;
    endfunction

    // The polarity bits sit directly above the last OR-mask, so o == n_out
    // naturally indexes them; anything beyond is clamped there.
    function automatic int unsigned or_mask_lsb(input int unsigned o,
                                                input int unsigned n_in,
                                                input int unsigned n_terms,
                                                input int unsigned n_out);
        int unsigned base;
        base = 2 * n_in * n_terms;
        if (o <= n_out) begin
            return base + n_terms * o;
        end
        return base + n_terms * n_out;
    endfunction

endpackage

// File: rtl/and_or_pla_term.sv
// One combinational product term.
//   in_i        : logic inputs
//   true_mask_i : inputs that must be 1 for the term to be true
//   comp_mask_i : inputs that must be 0 for the term to be true
//   term_o      : AND of the selected literals (1 when no mask bit is set,
//                 0 whenever an input is selected in both masks)
module and_or_pla_term #(
    parameter int unsigned N_IN = 4
) (
    input  logic [N_IN-1:0] in_i,
    input  logic [N_IN-1:0] true_mask_i,
    input  logic [N_IN-1:0] comp_mask_i,
    output logic            term_o
);

    logic [N_IN-1:0] lit_ok;

    always_comb begin
        lit_ok = (in_i | ~true_mask_i) & (~in_i | ~comp_mask_i);
        term_o = &lit_ok;
    end

endmodule

// File: rtl/and_or_pla.sv
// Runtime-programmable sum-of-products array with a serial config loader.
//   clk, rst_n          : clock, async active-low reset
//   in_valid, in        : input sample and its qualifier
//   out_valid, out      : registered results, 2-cycle latency; out holds when not valid
//   cfg_start           : begins (or restarts) a serial config load
//   cfg_valid, cfg_bit  : serial config stream, MSB first
//   cfg_ready           : high while loading
//   cfg_done            : one-cycle pulse the cycle after the new config is committed
module and_or_pla
    import and_or_pla_pkg::*;
#(
    parameter int unsigned N_IN    = 4,
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned N_OUT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in,
    output logic             out_valid,
    output logic [N_OUT-1:0] out,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_ready,
    output logic             cfg_done
);

    localparam int unsigned CFG_W  = cfg_width(N_IN, N_TERMS, N_OUT);
    localparam int unsigned CNT_W  = $clog2(CFG_W + 1);
    localparam int unsigned OR_LSB = or_mask_lsb(0, N_IN, N_TERMS, N_OUT);
    localparam int unsigned PO_LSB = or_mask_lsb(N_OUT, N_IN, N_TERMS, N_OUT);
    localparam int unsigned OR_W   = N_OUT * N_TERMS;

    // Config loader state
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic [CFG_W-1:0]   cfg_q, cfg_d;
    logic               cfg_done_q, cfg_done_d;

    // Pipeline state
    logic [N_TERMS-1:0] term_q, term_d;
    logic [OR_W-1:0]    or_q, or_d;
    logic [N_OUT-1:0]   pol_q, pol_d;
    logic               v1_q, v1_d;
    logic [N_OUT-1:0]   out_q, out_d;
    logic               v2_q, v2_d;

    logic [N_TERMS-1:0] term_vec;
    logic [CFG_W-1:0]   shift_val;

    // Terms always evaluate against the committed config, never the shadow.
    for (genvar t = 0; t < N_TERMS; t++) begin : g_term
        and_or_pla_term #(
            .N_IN (N_IN)
        ) u_term (
            .in_i        (in),
            .true_mask_i (cfg_q[term_true_lsb(t, N_IN) +: N_IN]),
            .comp_mask_i (cfg_q[term_true_lsb(t, N_IN) + N_IN +: N_IN]),
            .term_o      (term_vec[t])
        );
    end

    // Config loader
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        cfg_d      = cfg_q;
        cfg_done_d = 1'b0;
        shift_val  = {shadow_q[CFG_W-2:0], cfg_bit};

        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            LOAD: begin
                // A restart takes priority over a bit presented in the same cycle.
                if (cfg_start) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (cfg_valid) begin
                    shadow_d = shift_val;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(CFG_W - 1)) begin
                        cfg_d      = shift_val;
                        state_d    = IDLE;
                        cfg_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Evaluation pipeline. Stage 1 snapshots the OR-masks and polarity with the
    // terms so a commit between stages cannot mix two configurations.
    always_comb begin
        term_d = term_q;
        or_d   = or_q;
        pol_d  = pol_q;
        v1_d   = in_valid;
        if (in_valid) begin
            term_d = term_vec;
            or_d   = cfg_q[OR_LSB +: OR_W];
            pol_d  = cfg_q[PO_LSB +: N_OUT];
        end

        out_d = out_q;
        v2_d  = v1_q;
        if (v1_q) begin
            for (int o = 0; o < N_OUT; o++) begin
                out_d[o] = (|(term_q & or_q[o * N_TERMS +: N_TERMS])) ^ pol_q[o];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shadow_q   <= '0;
            cfg_q      <= '0;
            cfg_done_q <= 1'b0;
            term_q     <= '0;
            or_q       <= '0;
            pol_q      <= '0;
            v1_q       <= 1'b0;
            out_q      <= '0;
            v2_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            cfg_q      <= cfg_d;
            cfg_done_q <= cfg_done_d;
            term_q     <= term_d;
            or_q       <= or_d;
            pol_q      <= pol_d;
            v1_q       <= v1_d;
            out_q      <= out_d;
            v2_q       <= v2_d;
        end
    end

    assign out       = out_q;
    assign out_valid = v2_q;
    assign cfg_ready = (state_q == LOAD);
    assign cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_and_or_pla.sv
module tb_and_or_pla;

    localparam int unsigned N_IN    = 3;
    localparam int unsigned N_TERMS = 2;
    localparam int unsigned N_OUT   = 1;
    localparam int unsigned CFG_W   = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [N_IN-1:0]  din;
    logic             out_valid;
    logic [N_OUT-1:0] dout;
    logic             cfg_start;
    logic             cfg_valid;
    logic             cfg_bit;
    logic             cfg_ready;
    logic             cfg_done;

    int errors = 0;
    int checks = 0;
    int ndone  = 0;

    and_or_pla #(
        .N_IN    (N_IN),
        .N_TERMS (N_TERMS),
        .N_OUT   (N_OUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (din),
        .out_valid (out_valid),
        .out       (dout),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [CFG_W-1:0] ref_cfg;
    bit               loading;
    logic             bitq[$];
    bit               s1_v;
    logic             s1_val;
    bit               ov_e;
    logic             out_e;
    bit               done_e;

    // Direct reading of the array rules: each term is false as soon as one
    // selected literal is false; the output is the OR of the chosen terms,
    // optionally inverted.
    function automatic logic ref_eval(input logic [CFG_W-1:0] c, input logic [N_IN-1:0] x);
        logic any;
        any = 1'b0;
        for (int t = 0; t < int'(N_TERMS); t++) begin
            logic term;
            term = 1'b1;
            for (int i = 0; i < int'(N_IN); i++) begin
                if (c[6 * t + i] == 1'b1 && x[i] == 1'b0) term = 1'b0;
                if (c[6 * t + 3 + i] == 1'b1 && x[i] == 1'b1) term = 1'b0;
            end
            if (c[12 + t] == 1'b1 && term == 1'b1) any = 1'b1;
        end
        return any ^ c[14];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        ref_cfg = '0;
        loading = 1'b0;
        bitq.delete();
        s1_v    = 1'b0;
        s1_val  = 1'b0;
        ov_e    = 1'b0;
        out_e   = 1'b0;
        done_e  = 1'b0;
    endtask

    task automatic set_idle();
        in_valid  = 1'b0;
        din       = '0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
    endtask

    // One clock: inputs are already applied; advance the model at the edge,
    // compare every output on the following falling edge.
    task automatic cycle();
        @(posedge clk);
        ov_e = s1_v;
        if (s1_v) out_e = s1_val;
        s1_v = in_valid;
        if (in_valid) s1_val = ref_eval(ref_cfg, din);
        done_e = 1'b0;
        if (loading) begin
            if (cfg_start) begin
                bitq.delete();
            end else if (cfg_valid) begin
                bitq.push_back(cfg_bit);
                if (bitq.size() == int'(CFG_W)) begin
                    for (int k = 0; k < int'(CFG_W); k++) ref_cfg[CFG_W - 1 - k] = bitq[k];
                    bitq.delete();
                    loading = 1'b0;
                    done_e  = 1'b1;
                end
            end
        end else if (cfg_start) begin
            loading = 1'b1;
            bitq.delete();
        end
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(ov_e));
        check("out", 32'(dout), 32'(out_e));
        check("cfg_ready", 32'(cfg_ready), 32'(loading));
        check("cfg_done", 32'(cfg_done), 32'(done_e));
        if (cfg_done) ndone++;
    endtask

    // mode 0: no samples, 1: valid sample every cycle, 2: random valid
    task automatic tick(input int mode);
        case (mode)
            1: begin in_valid = 1'b1; din = 3'($urandom); end
            2: begin in_valid = 1'($urandom_range(0, 1)); din = 3'($urandom); end
            default: in_valid = 1'b0;
        endcase
        cycle();
    endtask

    task automatic send_cfg(input logic [CFG_W-1:0] v, input int mode, input bit gaps);
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        tick(mode);
        cfg_start = 1'b0;
        for (int k = int'(CFG_W) - 1; k >= 0; k--) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    cfg_valid = 1'b0;
                    tick(mode);
                end
            end
            cfg_valid = 1'b1;
            cfg_bit   = v[k];
            tick(mode);
        end
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        tick(mode);
    endtask

    typedef struct {
        logic [CFG_W-1:0] cfg;
        logic [N_IN-1:0]  x;
        logic             y;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [CFG_W-1:0] cur;
        logic [CFG_W-1:0] v7103;
        logic [CFG_W-1:0] v3103;
        v7103 = 15'h7103;
        v3103 = 15'h3103;

        // f = (in0 & in1) | in2, then its inverse
        for (int i = 0; i < 8; i++) begin
            logic [N_IN-1:0] x;
            x = 3'(i);
            vecs[i]     = '{cfg: v3103, x: x, y: (x[0] & x[1]) | x[2]};
            vecs[i + 8] = '{cfg: v7103, x: x, y: ~((x[0] & x[1]) | x[2])};
        end
        // Spot values straight from the function description
        check("tbl_011", 32'(vecs[3].y), 32'h1);
        check("tbl_001", 32'(vecs[1].y), 32'h0);

        set_idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        check("rst_out", 32'(dout), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'h0);
        check("rst_cfg_done", 32'(cfg_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unprogrammed array evaluates 0; valid appears exactly 2 cycles later.
        in_valid = 1'b1;
        din      = 3'b111;
        cycle();
        in_valid = 1'b0;
        check("lat_not_yet", 32'(out_valid), 32'h0);
        cycle();
        check("lat_2cyc_valid", 32'(out_valid), 32'h1);
        check("lat_2cyc_out", 32'(dout), 32'h0);
        cycle();

        // Table sweep over both functions
        cur = '0;
        for (int n = 0; n < 16; n++) begin
            if (vecs[n].cfg !== cur) begin
                ndone = 0;
                send_cfg(vecs[n].cfg, 0, 1'b0);
                check("load_done_once", 32'(ndone), 32'h1);
                cur = vecs[n].cfg;
            end
            in_valid = 1'b1;
            din      = vecs[n].x;
            cycle();
            in_valid = 1'b0;
            cycle();
            check("table_out", 32'(dout), 32'(vecs[n].y));
            cycle();
        end

        // Stream samples every cycle straight across the commit of 0x3103
        send_cfg(v3103, 1, 1'b0);
        repeat (4) tick(1);

        // Restart mid-load: 7 bits of 0x7103, then restart with a bit that
        // must be dropped, then the full 0x3103 with gaps.
        send_cfg(v7103, 0, 1'b0);
        ndone     = 0;
        cfg_start = 1'b1;
        tick(2);
        cfg_start = 1'b0;
        for (int k = int'(CFG_W) - 1; k >= int'(CFG_W) - 7; k--) begin
            cfg_valid = 1'b1;
            cfg_bit   = v7103[k];
            tick(2);
        end
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick(2);
        cfg_start = 1'b0;
        for (int k = int'(CFG_W) - 1; k >= 0; k--) begin
            repeat ($urandom_range(0, 2)) begin
                cfg_valid = 1'b0;
                tick(2);
            end
            cfg_valid = 1'b1;
            cfg_bit   = v3103[k];
            tick(2);
        end
        cfg_valid = 1'b0;
        repeat (3) tick(2);
        check("restart_done_once", 32'(ndone), 32'h1);
        check("restart_cfg", 32'(ref_cfg), 32'h3103);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            din      = 3'(i);
            cycle();
        end
        in_valid = 1'b0;
        repeat (2) cycle();

        // Random configurations under random traffic
        for (int r = 0; r < 12; r++) begin
            send_cfg(15'($urandom), 2, 1'b1);
            repeat (10) tick(2);
        end
        cfg_valid = 1'b1;      // ignored outside LOAD
        cfg_bit   = 1'b1;
        repeat (5) tick(1);
        cfg_valid = 1'b0;

        // Reset mid-load (after 9 bits) while samples stream
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        for (int k = int'(CFG_W) - 1; k >= int'(CFG_W) - 9; k--) begin
            cfg_valid = 1'b1;
            cfg_bit   = v3103[k];
            tick(1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out", 32'(dout), 32'h0);
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_cfg_ready", 32'(cfg_ready), 32'h0);
        set_idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            din      = 3'(i);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("resume_out", 32'(dout), 32'h0);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
